// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with an in-order prefetch queue and redirect flush.
// Latency: one request per cycle; a response is visible at the queue head one cycle after it returns.
// Backpressure: stops issuing when queue plus in-flight reach DEPTH; mem_valid is never stalled.
// Optional perf counters are enabled with `define FETCH_PERF_EN.

// Small in-order FIFO. The caller guarantees it is never pushed when full or popped when empty.
module fetch_queue_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // DEPTH need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Pointer update; flush discards every entry at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_rdy)  rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   // Storage write; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (push_vld && !flush) mem[wr_ptr] <= push_dat;
   end

   assign pop_dat = mem[rd_ptr];
endmodule

module fetch_queue #(
   parameter int              XLEN            = 32,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mispredict_in,
   input  logic [XLEN-1:0] correct_pc_in,
   input  logic            predict_taken_in,
   input  logic [XLEN-1:0] predict_target_in,
   output logic            request,
   output logic [XLEN-1:0] address_out,
   output logic [3:0]      mask,
   output logic            we_re,
   input  logic            mem_ready,
   input  logic            mem_valid,
   input  logic [XLEN-1:0] instruction_fetch,
   output logic            instr_valid,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_req_count,
   output logic [31:0]     perf_drop_count
`endif
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int OCC_W  = CNT_W + 1;
   // Stale responses can pile up across back-to-back redirects under long memory latency.
   localparam int DROP_W = 8;

   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   q_pc    [DEPTH];
   logic [XLEN-1:0]   q_instr [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [OUT_W-1:0]  outstanding;
   logic [DROP_W-1:0] drop_cnt;

   logic              deq;
   logic              take_redirect;
   logic              redirect;
   logic              accept;
   logic              resp_keep;
   logic              resp_drop;
   logic [OCC_W-1:0]  occupancy;
   logic [XLEN-1:0]   pend_pc;

   assign mask        = 4'b1111;
   assign we_re       = 1'b0;
   assign address_out = pc;
   assign instr_valid = (count != '0);
   // Outputs read as zero when empty so nothing uninitialised leaks out of storage.
   assign instruction = instr_valid ? q_instr[rd_ptr] : '0;
   assign instr_pc    = instr_valid ? q_pc[rd_ptr]    : '0;

   // Issue/accept/response classification; any redirect kills issue and the arriving response.
   always_comb begin
      deq           = instr_valid && instr_ready;
      take_redirect = !mispredict_in && predict_taken_in && deq;
      redirect      = mispredict_in || take_redirect;
      occupancy     = OCC_W'(count) + OCC_W'(outstanding);
      request       = rst && !redirect
                      && (outstanding < OUT_W'(MAX_OUTSTANDING))
                      && (occupancy < OCC_W'(DEPTH));
      accept        = request && mem_ready;
      resp_drop     = mem_valid && ((drop_cnt != '0) || redirect);
      resp_keep     = mem_valid && (drop_cnt == '0) && !redirect;
   end

   // Fetch PC: mispredict beats predicted-taken, which beats sequential advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              pc <= RESET_PC;
      else if (mispredict_in) pc <= correct_pc_in;
      else if (take_redirect) pc <= predict_target_in;
      else if (accept)        pc <= pc + XLEN'(4);
   end

   // Queue pointers and occupancy; a redirect always leaves the queue empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (resp_keep) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq)       rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(resp_keep) - CNT_W'(deq);
      end
   end

   // Queue storage write of {pc, instruction}.
   always_ff @(posedge clk) begin
      if (resp_keep) begin
         q_pc[wr_ptr]    <= pend_pc;
         q_instr[wr_ptr] <= instruction_fetch;
      end
   end

   // In-flight tracking. On redirect every live request becomes stale; a response arriving
   // that same cycle is one of them (or an already-stale one), so it is subtracted once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (redirect) begin
         outstanding <= '0;
         drop_cnt    <= drop_cnt + DROP_W'(outstanding) - DROP_W'(mem_valid);
      end else begin
         outstanding <= outstanding + OUT_W'(accept) - OUT_W'(resp_keep);
         if (mem_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - DROP_W'(1);
      end
   end

   // Pending-PC FIFO holds only live-path requests: flushed on redirect, so stale
   // responses never pop it and it never needs more than MAX_OUTSTANDING entries.
   fetch_queue_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTSTANDING)
   ) u_pend_pc (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .push_vld (accept),
      .push_dat (pc),
      .pop_rdy  (resp_keep),
      .pop_dat  (pend_pc)
   );

`ifdef FETCH_PERF_EN
   // Free-running wrapping event counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_req_count  <= '0;
         perf_drop_count <= '0;
      end else begin
         if (accept)    perf_req_count  <= perf_req_count + 32'd1;
         if (resp_drop) perf_drop_count <= perf_drop_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            mispredict_in = 1'b0;
   logic [XLEN-1:0] correct_pc_in = '0;
   logic            predict_taken_in = 1'b0;
   logic [XLEN-1:0] predict_target_in = '0;
   logic            request;
   logic [XLEN-1:0] address_out;
   logic [3:0]      mask;
   logic            we_re;
   logic            mem_ready = 1'b1;
   logic            mem_valid = 1'b0;
   logic [XLEN-1:0] instruction_fetch = '0;
   logic            instr_valid;
   logic [XLEN-1:0] instruction;
   logic [XLEN-1:0] instr_pc;
   logic            instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
   logic [31:0]     perf_req_count;
   logic [31:0]     perf_drop_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_queue #(
      .XLEN(XLEN), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h100)
   ) dut (
      .clk(clk), .rst(rst),
      .mispredict_in(mispredict_in), .correct_pc_in(correct_pc_in),
      .predict_taken_in(predict_taken_in), .predict_target_in(predict_target_in),
      .request(request), .address_out(address_out), .mask(mask), .we_re(we_re),
      .mem_ready(mem_ready), .mem_valid(mem_valid), .instruction_fetch(instruction_fetch),
      .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
      , .perf_req_count(perf_req_count), .perf_drop_count(perf_drop_count)
`endif
   );

   // Memory model: fixed latency, in-order responses, data derived from the address.
   logic [XLEN-1:0] mq_addr[$];
   int              mq_due[$];
   int              cyc = 0;
   int              lat = 1;

   function automatic logic [XLEN-1:0] data_of(input logic [XLEN-1:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         mq_addr.delete();
         mq_due.delete();
      end else begin
         if (mem_valid && mq_addr.size() > 0) begin
            mq_addr.delete(0);
            mq_due.delete(0);
         end
         if (request && mem_ready) begin
            mq_addr.push_back(address_out);
            mq_due.push_back(cyc + lat);
         end
      end
   end

   always @(negedge clk) begin
      if (rst && mq_addr.size() > 0 && mq_due[0] <= cyc + 1) begin
         mem_valid         = 1'b1;
         instruction_fetch = data_of(mq_addr[0]);
      end else begin
         mem_valid         = 1'b0;
         instruction_fetch = '0;
      end
   end

   task automatic apply_reset(input int l);
      rst = 1'b0;
      mispredict_in = 1'b0; predict_taken_in = 1'b0; instr_ready = 1'b0; mem_ready = 1'b1;
      correct_pc_in = '0; predict_target_in = '0; lat = l;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic wait_valid(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk); #1;
         if (instr_valid) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk); #1;
      n_tests++; if (request !== 1'b0) begin n_fail++; $display("FAIL reset_request: got %b want 0", request); end
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_tests++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instruction); end
      n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
      n_tests++; if (address_out !== 32'h100) begin n_fail++; $display("FAIL reset_addr: got %h want 100", address_out); end
      n_tests++; if (mask !== 4'hF || we_re !== 1'b0) begin n_fail++; $display("FAIL reset_mask_we: got %h/%b want f/0", mask, we_re); end
   endtask

   task automatic test_stream();
      logic [XLEN-1:0] exp_pc;
      apply_reset(1);
      instr_ready = 1'b1;
      n_tests++; if (request !== 1'b1 || address_out !== 32'h100) begin n_fail++; $display("FAIL stream_first_req: got %b/%h want 1/100", request, address_out); end
      @(negedge clk); #1;
      n_tests++; if (address_out !== 32'h104 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_second_req: got %h/%b want 104/0", address_out, instr_valid); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         exp_pc = 32'h100 + 32'(4 * k);
         n_tests++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %b/%h want 1/%h", k, instr_valid, instr_pc, exp_pc); end
         n_tests++; if (instruction !== data_of(exp_pc)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", k, instruction, data_of(exp_pc)); end
      end
   endtask

   task automatic test_backpressure();
      logic [XLEN-1:0] exp_pc;
      apply_reset(1);
      instr_ready = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_tests++; if (request !== 1'b0) begin n_fail++; $display("FAIL bp_request[%0d]: got %b want 0", i, request); end
         n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin n_fail++; $display("FAIL bp_head[%0d]: got %b/%h want 1/100", i, instr_valid, instr_pc); end
         n_tests++; if (address_out !== 32'h110) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h want 110", i, address_out); end
      end
      instr_ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk); #1;
         exp_pc = 32'h100 + 32'(4 * k);
         n_tests++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin n_fail++; $display("FAIL bp_drain[%0d]: got %b/%h want 1/%h", k, instr_valid, instr_pc, exp_pc); end
      end
   endtask

   task automatic test_mispredict();
      bit ok;
      apply_reset(3);
      instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      mispredict_in = 1'b1; correct_pc_in = 32'h200; predict_target_in = 32'h900;
      #1;
      n_tests++; if (request !== 1'b0) begin n_fail++; $display("FAIL mp_request_low: got %b want 0", request); end
      @(negedge clk);
      mispredict_in = 1'b0;
      #1;
      n_tests++; if (request !== 1'b1 || address_out !== 32'h200) begin n_fail++; $display("FAIL mp_new_req: got %b/%h want 1/200", request, address_out); end
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mp_valid_low: got %b want 0", instr_valid); end
      wait_valid(20, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL mp_timeout: got no valid want valid"); end
      else if (instr_pc !== 32'h200 || instruction !== data_of(32'h200)) begin
         n_fail++; $display("FAIL mp_first_pc: got %h/%h want 200/%h", instr_pc, instruction, data_of(32'h200));
      end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_drop_count !== 32'd2) begin n_fail++; $display("FAIL mp_perf_drop: got %0d want 2", perf_drop_count); end
      n_tests++; if (perf_req_count !== 32'd4) begin n_fail++; $display("FAIL mp_perf_req: got %0d want 4", perf_req_count); end
`endif
   endtask

   task automatic test_predict_taken();
      bit ok;
      apply_reset(1);
      instr_ready = 1'b1;
      repeat (3) @(negedge clk); #1;
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin n_fail++; $display("FAIL pt_head: got %b/%h want 1/104", instr_valid, instr_pc); end
      predict_taken_in = 1'b1; predict_target_in = 32'h300;
      #1;
      n_tests++; if (request !== 1'b0) begin n_fail++; $display("FAIL pt_request_low: got %b want 0", request); end
      @(negedge clk);
      predict_taken_in = 1'b0;
      #1;
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL pt_flushed: got %b want 0", instr_valid); end
      n_tests++; if (request !== 1'b1 || address_out !== 32'h300) begin n_fail++; $display("FAIL pt_new_req: got %b/%h want 1/300", request, address_out); end
      wait_valid(10, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL pt_timeout: got no valid want valid"); end
      else if (instr_pc !== 32'h300 || instruction !== data_of(32'h300)) begin
         n_fail++; $display("FAIL pt_first_pc: got %h/%h want 300/%h", instr_pc, instruction, data_of(32'h300));
      end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_drop_count !== 32'd1) begin n_fail++; $display("FAIL pt_perf_drop: got %0d want 1", perf_drop_count); end
      n_tests++; if (perf_req_count !== 32'd5) begin n_fail++; $display("FAIL pt_perf_req: got %0d want 5", perf_req_count); end
`endif
      @(negedge clk); #1;
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h304) begin n_fail++; $display("FAIL pt_second_pc: got %b/%h want 1/304", instr_valid, instr_pc); end
   endtask

   task automatic test_simultaneous();
      bit ok;
      apply_reset(1);
      instr_ready = 1'b1;
      repeat (3) @(negedge clk);
      mispredict_in = 1'b1; correct_pc_in = 32'h200;
      predict_taken_in = 1'b1; predict_target_in = 32'h300;
      #1;
      n_tests++; if (request !== 1'b0) begin n_fail++; $display("FAIL sim_request_low: got %b want 0", request); end
      @(negedge clk);
      mispredict_in = 1'b0; predict_taken_in = 1'b0;
      #1;
      n_tests++; if (request !== 1'b1 || address_out !== 32'h200) begin n_fail++; $display("FAIL sim_target: got %b/%h want 1/200", request, address_out); end
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL sim_valid_low: got %b want 0", instr_valid); end
      wait_valid(10, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL sim_timeout: got no valid want valid"); end
      else if (instr_pc !== 32'h200) begin n_fail++; $display("FAIL sim_first_pc: got %h want 200", instr_pc); end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_drop_count !== 32'd1) begin n_fail++; $display("FAIL sim_perf_drop: got %0d want 1", perf_drop_count); end
`endif
   endtask

   task automatic test_async_reset();
      bit ok;
      apply_reset(2);
      instr_ready = 1'b0;
      repeat (5) @(negedge clk); #1;
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || address_out !== 32'h110) begin
         n_fail++; $display("FAIL ar_pre: got %b/%h/%h want 1/100/110", instr_valid, instr_pc, address_out);
      end
      #1;
      rst = 1'b0; mem_valid = 1'b0;
      #1;
      n_tests++; if (request !== 1'b0 || address_out !== 32'h100) begin n_fail++; $display("FAIL ar_req_addr: got %b/%h want 0/100", request, address_out); end
      n_tests++; if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instruction !== 32'h0) begin
         n_fail++; $display("FAIL ar_outputs: got %b/%h/%h want 0/0/0", instr_valid, instr_pc, instruction);
      end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_req_count !== 32'd0 || perf_drop_count !== 32'd0) begin n_fail++; $display("FAIL ar_perf: got %0d/%0d want 0/0", perf_req_count, perf_drop_count); end
`endif
      lat = 1;
      @(negedge clk);
      rst = 1'b1; instr_ready = 1'b1;
      #1;
      n_tests++; if (request !== 1'b1 || address_out !== 32'h100) begin n_fail++; $display("FAIL ar_restart: got %b/%h want 1/100", request, address_out); end
      wait_valid(10, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL ar_timeout: got no valid want valid"); end
      else if (instr_pc !== 32'h100 || instruction !== data_of(32'h100)) begin
         n_fail++; $display("FAIL ar_first_pc: got %h/%h want 100/%h", instr_pc, instruction, data_of(32'h100));
      end
      @(negedge clk); #1;
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin n_fail++; $display("FAIL ar_second_pc: got %b/%h want 1/104", instr_valid, instr_pc); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_mispredict();
      test_predict_taken();
      test_simultaneous();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000ns, want finished");
      $fatal(1, "watchdog");
   end
endmodule
